// File: rtl/barrett_mult_param.sv
// Digit-serial Barrett modular multiplier: z = (x*y) mod m, with a caller-supplied mu = floor(2^(2N)/m).
// One shared W x (N+1) multiplier is reused for x*y, the quotient estimate and q*m.
module barrett_mult_param #(
  parameter int N = 192,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] m,
  input  logic [N:0]   mu,
  output logic [N-1:0] z,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int D  = N / W;
  localparam int E  = (N + W) / W;   // ceil((N+1)/W)
  localparam int CW = $clog2(E + 1);
  localparam logic [CW-1:0] d_last = CW'(D - 1);
  localparam logic [CW-1:0] e_last = CW'(E - 1);

  if (N % W != 0) begin : g_bad_width
    $error("barrett_mult_param: N must be a multiple of W");
  end

  typedef enum logic [2:0] {
    s_idle, s_mul, s_qest, s_qm, s_sub, s_corr, s_err
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            accept;

  logic [N-1:0]    x_reg, y_sh, m_reg, q_sh;
  logic [N:0]      mu_sh;
  logic [2*N-1:0]  p_reg;
  logic [2*N+1:0]  t_reg, t_sum;
  logic [N+1:0]    r_reg, r_corr, m_ext;

  logic [N:0]      mul_a;
  logic [W-1:0]    mul_b;
  logic [N+W:0]    prod;
  logic [2*N+1:0]  term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= s_idle;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    accept     = 1'b0;
    case (state_reg)
      s_idle: begin
        cnt_next = '0;
        if (start) begin
          accept     = 1'b1;
          state_next = m[N-1] ? s_mul : s_err;
        end
      end
      s_mul: if (cnt_reg == d_last) begin
        state_next = s_qest;
        cnt_next   = '0;
      end
      s_qest: if (cnt_reg == e_last) begin
        state_next = s_qm;
        cnt_next   = '0;
      end
      s_qm: if (cnt_reg == d_last) begin
        state_next = s_sub;
        cnt_next   = '0;
      end
      s_sub: begin
        state_next = s_corr;
        cnt_next   = '0;
      end
      s_corr: if (cnt_reg == CW'(1)) begin
        state_next = s_idle;
        cnt_next   = '0;
      end
      default: begin
        state_next = s_idle;
        cnt_next   = '0;
      end
    endcase
  end

  // Operand routing for the shared multiplier; digits are consumed LSD first from shift registers.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      s_mul: begin
        mul_a = (N+1)'(x_reg);
        mul_b = y_sh[W-1:0];
      end
      s_qest: begin
        mul_a = p_reg[2*N-1:N-1];
        mul_b = mu_sh[W-1:0];
      end
      s_qm: begin
        mul_a = (N+1)'(m_reg);
        mul_b = q_sh[W-1:0];
      end
      default: ;
    endcase
  end

  assign prod   = (N+W+1)'(mul_a) * (N+W+1)'(mul_b);
  assign term   = (2*N+2)'(prod) << (W * cnt_reg);
  assign t_sum  = t_reg + term;
  assign m_ext  = (N+2)'(m_reg);
  assign r_corr = (r_reg >= m_ext) ? r_reg - m_ext : r_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg <= '0;
      y_sh  <= '0;
      m_reg <= '0;
      mu_sh <= '0;
      q_sh  <= '0;
      p_reg <= '0;
      t_reg <= '0;
      r_reg <= '0;
      z     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != s_idle);
      case (state_reg)
        s_idle: if (accept) begin
          x_reg <= x;
          y_sh  <= y;
          m_reg <= m;
          mu_sh <= mu;
          q_sh  <= '0;
          p_reg <= '0;
          t_reg <= '0;
          r_reg <= '0;
        end
        s_mul: begin
          p_reg <= p_reg + term[2*N-1:0];
          y_sh  <= y_sh >> W;
        end
        s_qest: begin
          t_reg <= t_sum;
          mu_sh <= mu_sh >> W;
          if (cnt_reg == e_last) q_sh <= t_sum[N+1 +: N];
        end
        // Only the low N+2 bits of q*m matter: P - q*m < 3m always fits there.
        s_qm: begin
          r_reg <= r_reg + term[N+1:0];
          q_sh  <= q_sh >> W;
        end
        s_sub: r_reg <= p_reg[N+1:0] - r_reg;
        s_corr: begin
          r_reg <= r_corr;
          if (cnt_reg == CW'(1)) begin
            z    <= r_corr[N-1:0];
            done <= 1'b1;
            err  <= 1'b0;
          end
        end
        s_err: begin
          z    <= '0;
          done <= 1'b1;
          err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
